// File: rtl/bnn_tb_pkg.sv
// Shared types and default sizing for the BNN stimulus player.
package bnn_tb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/bnn_vec_mem.sv
// Stimulus store: DEPTH x DATA_W register array, synchronous write,
// asynchronous read, no reset.
module bnn_vec_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; contents deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bnn_vec_player.sv
// Streams preloaded binary input vectors to the BNN netlist over a
// valid/ready handshake, with a one-cycle done pulse at the end of a run.
module bnn_vec_player
  import bnn_tb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   vec_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   vec_cnt_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [ADDR_W:0]   n_clamp;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic              hs;

  assign n_clamp = (num_vec > DEPTH_L) ? DEPTH_L : num_vec;
  assign mem_we  = load_en && (state_q == ST_IDLE);
  assign hs      = out_valid_q && out_ready;
  // In IDLE slot 0 is presented so an accepted start can capture it; since
  // the write lands on the same edge, a same-cycle write to slot 0 is not seen.
  assign rd_addr = (state_q == ST_IDLE) ? '0 : rd_addr_q;

  bnn_vec_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(load_addr),
    .wdata_i(load_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // Control FSM with registered outputs and run bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_cnt_q   <= '0;
      n_q         <= '0;
      rd_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            vec_cnt_q <= '0;
            n_q       <= n_clamp;
            busy_q    <= 1'b1;
            if (n_clamp == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_STREAM;
              out_valid_q <= 1'b1;
              out_data_q  <= rd_data;
              out_last_q  <= (n_clamp == (ADDR_W + 1)'(1));
              rd_addr_q   <= (ADDR_W)'(1);
            end
          end
        end
        ST_STREAM: begin
          if (hs) begin
            vec_cnt_q <= vec_cnt_q + (ADDR_W + 1)'(1);
            if (out_last_q) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_data_q <= rd_data;
              out_last_q <= ((vec_cnt_q + (ADDR_W + 1)'(2)) == n_q);
              rd_addr_q  <= rd_addr_q + (ADDR_W)'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_bnn_vec_player.sv
// Scoreboard bench for bnn_vec_player: stimulus queues expected vectors,
// a negedge monitor pops and compares on every handshake.
module tb_bnn_vec_player;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [ADDR_W:0]   num_vec;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   vec_cnt;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                n_pass = 0;
  int                n_total = 0;

  always #5 clk = ~clk;

  bnn_vec_player #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start    (start),
    .num_vec  (num_vec),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .vec_cnt  (vec_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every handshake and every stall cycle against the queue head.
  always @(negedge clk) begin
    if (rstn === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got data %h with empty queue expected no valid", out_data);
      end else if (out_ready === 1'b1) begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_data", out_data, e.data);
        chk("hs_last", 32'(out_last), 32'(e.last));
      end else begin
        chk("stall_data", out_data, sb[0].data);
        chk("stall_last", 32'(out_last), 32'(sb[0].last));
      end
    end
  end

  task automatic write_slot(input int a, input logic [DATA_W-1:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    model[a]  = d;
    tick();
    load_en   = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic run(input int nreq, input int nexp, input int mode, input bit inject,
                     input bit wr0, input logic [DATA_W-1:0] wr0_data);
    int cyc;
    for (int i = 0; i < nexp; i++) begin
      exp_t e;
      e.data = model[i];
      e.last = (i == nexp - 1);
      sb.push_back(e);
    end
    start   = 1'b1;
    num_vec = (ADDR_W + 1)'(nreq);
    if (wr0) begin
      load_en   = 1'b1;
      load_addr = '0;
      load_data = wr0_data;
    end
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    if (wr0) model[0] = wr0_data;
    chk("first_valid", 32'(out_valid), 32'(nexp != 0));
    chk("busy_run", 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (inject && cyc == 2) begin
        start     = 1'b1;
        num_vec   = 5'd1;
        load_en   = 1'b1;
        load_addr = 4'd2;
        load_data = 32'hDEAD_BEEF;
      end else begin
        start   = 1'b0;
        load_en = 1'b0;
      end
      tick();
      cyc++;
    end
    start   = 1'b0;
    load_en = 1'b0;
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    if (mode == 0) chk("latency", 32'(cyc), 32'(nexp));
    chk("done_valid_low", 32'(out_valid), 32'd0);
    chk("vec_cnt", 32'(vec_cnt), 32'(nexp));
    chk("queue_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; num_vec = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(vec_cnt), 32'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) write_slot(i, 32'hA5A5_0000 + 32'(i));
    for (int i = 4; i < DEPTH; i++) write_slot(i, 32'h1000_0000 + 32'(i) * 32'h0101);

    run(4, 4, 0, 1'b0, 1'b0, '0);                  // full throughput
    run(4, 4, 1, 1'b0, 1'b0, '0);                  // stalls
    run(0, 0, 0, 1'b0, 1'b0, '0);                  // empty run
    run(20, 16, 0, 1'b0, 1'b0, '0);                // clamped to DEPTH
    run(4, 4, 1, 1'b1, 1'b0, '0);                  // start + write while busy
    run(4, 4, 0, 1'b0, 1'b0, '0);                  // slot 2 must be unchanged
    run(2, 2, 0, 1'b0, 1'b1, 32'h0BAD_F00D);       // same-cycle write: old slot 0
    run(1, 1, 0, 1'b0, 1'b0, '0);                  // new slot 0 now visible

    // Reset after two of four vectors accepted.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = model[i];
      e.last = (i == 3);
      sb.push_back(e);
    end
    out_ready = 1'b0;
    start = 1'b1;
    num_vec = 5'd4;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_cnt", 32'(vec_cnt), 32'd2);
    rstn = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cnt", 32'(vec_cnt), 32'd0);
    sb.delete();
    rstn = 1'b1;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    tick();
    chk("post_rst_done2", 32'(done), 32'd0);
    run(4, 4, 0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
